// File: rtl/wash_panel_if.sv
// Signal bundle between the wash panel and its surroundings (coin acceptor, buttons, washer).
// The panel takes the slave side; the washer/test side takes the master side.
interface wash_panel_if;
  logic       i_coin_raw;
  logic [3:0] i_btn_mode;
  logic       i_btn_cancel;
  logic       i_idle;
  logic       i_ready;
  logic       i_done;
  logic       o_start;
  logic       o_coin;
  logic       o_mode_1;
  logic       o_mode_2;
  logic       o_mode_3;
  logic       o_mode_4;
  logic       o_cancel;
  logic [3:0] o_credit;
  logic       o_refund;
  logic [3:0] o_refund_cnt;

  modport slave (
    input  i_coin_raw, i_btn_mode, i_btn_cancel, i_idle, i_ready, i_done,
    output o_start, o_coin, o_mode_1, o_mode_2, o_mode_3, o_mode_4,
           o_cancel, o_credit, o_refund, o_refund_cnt
  );

  modport master (
    output i_coin_raw, i_btn_mode, i_btn_cancel, i_idle, i_ready, i_done,
    input  o_start, o_coin, o_mode_1, o_mode_2, o_mode_3, o_mode_4,
           o_cancel, o_credit, o_refund, o_refund_cnt
  );
endinterface

// File: rtl/wash_panel.sv
// Coin-operated washer front panel: synchronised/debounced inputs, credit bookkeeping
// and the wash-sequencing state machine with registered outputs.
module wash_panel #(
  parameter int PRICE       = 3,
  parameter int DEB_CYC     = 5,
  parameter int SEL_TIMEOUT = 7500
) (
  input logic         i_clk,
  input logic         i_rst_n,
  wash_panel_if.slave bus
);

  localparam int CW = $clog2(DEB_CYC + 1);
  localparam int TW = $clog2(SEL_TIMEOUT + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);
  localparam logic [CW-1:0] DEB_FULL = CW'(DEB_CYC);
  localparam logic [TW-1:0] SEL_LAST = TW'(SEL_TIMEOUT - 1);
  localparam logic [5:0]    PRICE6   = 6'(PRICE);

  typedef enum logic [2:0] {P_INIT, P_CREDIT, P_COIN, P_SELECT, P_RUN, P_ABORT} state_t;

  // bit 0 = coin, bits 4:1 = mode buttons, bit 5 = cancel
  logic [5:0]    raw, sync1, sync2, deb_pulse;
  logic [CW-1:0] deb_cnt [6];
  logic          coin_p, cancel_p;
  logic [3:0]    mode_p;

  state_t        state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [3:0]    credit, credit_nx, mode, mode_nx, refund_cnt, refund_cnt_nx;
  logic          start, start_nx, coin_lvl, coin_nx, cancel, cancel_nx, refund, refund_nx;
  logic          add_back, take_price, clear_credit;
  logic [5:0]    credit_sum;

  assign raw      = {bus.i_btn_cancel, bus.i_btn_mode, bus.i_coin_raw};
  assign coin_p   = deb_pulse[0];
  assign mode_p   = deb_pulse[4:1];
  assign cancel_p = deb_pulse[5];

  // The counter parks at DEB_FULL while the level stays high, so one press gives one pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      deb_pulse <= '0;
      for (int i = 0; i < 6; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 6; i++) begin
        if (!sync2[i]) begin
          deb_cnt[i]   <= '0;
          deb_pulse[i] <= 1'b0;
        end else if (deb_cnt[i] != DEB_FULL) begin
          deb_cnt[i]   <= deb_cnt[i] + CW'(1);
          deb_pulse[i] <= (deb_cnt[i] == DEB_LAST);
        end else begin
          deb_pulse[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= P_INIT;
      timer      <= '0;
      credit     <= '0;
      mode       <= '0;
      start      <= 1'b0;
      coin_lvl   <= 1'b0;
      cancel     <= 1'b0;
      refund     <= 1'b0;
      refund_cnt <= '0;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      credit     <= credit_nx;
      mode       <= mode_nx;
      start      <= start_nx;
      coin_lvl   <= coin_nx;
      cancel     <= cancel_nx;
      refund     <= refund_nx;
      refund_cnt <= refund_cnt_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    timer_nx      = '0;
    mode_nx       = '0;
    start_nx      = 1'b0;
    cancel_nx     = 1'b0;
    refund_nx     = 1'b0;
    refund_cnt_nx = '0;
    add_back      = 1'b0;
    take_price    = 1'b0;
    clear_credit  = 1'b0;
    case (state)
      P_INIT: begin
        start_nx = 1'b1;
        state_nx = P_CREDIT;
      end
      P_CREDIT: begin
        if (cancel_p && credit != 4'd0) begin
          refund_nx     = 1'b1;
          refund_cnt_nx = credit;
          clear_credit  = 1'b1;
        end else if ({2'b00, credit} >= PRICE6 && bus.i_idle) begin
          take_price = 1'b1;
          state_nx   = P_COIN;
        end
      end
      P_COIN: begin
        if (cancel_p) begin
          cancel_nx = 1'b1;
          add_back  = 1'b1;
          state_nx  = P_ABORT;
        end else if (bus.i_ready) begin
          state_nx = P_SELECT;
        end
      end
      P_SELECT: begin
        if (cancel_p) begin
          cancel_nx = 1'b1;
          add_back  = 1'b1;
          state_nx  = P_ABORT;
        end else if (mode_p != 4'd0) begin
          // Isolate the lowest set bit so simultaneous presses resolve to the lowest mode.
          mode_nx  = mode_p & (~mode_p + 4'd1);
          state_nx = P_RUN;
        end else if (timer == SEL_LAST) begin
          cancel_nx = 1'b1;
          add_back  = 1'b1;
          state_nx  = P_ABORT;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      P_RUN: begin
        if (cancel_p) begin
          cancel_nx = 1'b1;
          state_nx  = P_ABORT;
        end else if (bus.i_done) begin
          state_nx = P_CREDIT;
        end else begin
          mode_nx = mode;
        end
      end
      P_ABORT: begin
        if (bus.i_idle) state_nx = P_CREDIT;
      end
      default: state_nx = P_INIT;
    endcase

    coin_nx = (state_nx == P_COIN);

    // Coins are counted in every state, even alongside a refund, price deduction or payback.
    credit_sum = (clear_credit ? 6'd0 : {2'b00, credit})
               + {5'd0, coin_p}
               + (add_back ? PRICE6 : 6'd0)
               - (take_price ? PRICE6 : 6'd0);
    credit_nx  = (credit_sum > 6'd15) ? 4'd15 : credit_sum[3:0];
  end

  assign bus.o_start      = start;
  assign bus.o_coin       = coin_lvl;
  assign bus.o_mode_1     = mode[0];
  assign bus.o_mode_2     = mode[1];
  assign bus.o_mode_3     = mode[2];
  assign bus.o_mode_4     = mode[3];
  assign bus.o_cancel     = cancel;
  assign bus.o_credit     = credit;
  assign bus.o_refund     = refund;
  assign bus.o_refund_cnt = refund_cnt;

endmodule

// File: tb/tb_wash_panel.sv
// Directed bench for wash_panel: one linear stimulus sequence with hand-computed expectations.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_wash_panel;

  localparam int SEL_TIMEOUT = 7500;
  localparam logic [5:0] COIN   = 6'b000001;
  localparam logic [5:0] CANCEL = 6'b100000;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wash_panel_if wif ();

  wash_panel #(.PRICE(3), .DEB_CYC(5), .SEL_TIMEOUT(SEL_TIMEOUT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (wif)
  );

  function automatic logic [5:0] mode_bits(input int k);
    return 6'(2 << k);
  endfunction

  function automatic logic [3:0] modes();
    return {wif.o_mode_4, wif.o_mode_3, wif.o_mode_2, wif.o_mode_1};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold the selected raw inputs for 'hold' cycles; returns on the falling edge right after
  // the clock edge at which the panel acts on the debounced pulse (8 edges after the press).
  task automatic apply_stimulus(input logic [5:0] bits, input int hold);
    wif.i_coin_raw   = bits[0];
    wif.i_btn_mode   = bits[4:1];
    wif.i_btn_cancel = bits[5];
    tick(hold);
    wif.i_coin_raw   = 1'b0;
    wif.i_btn_mode   = 4'd0;
    wif.i_btn_cancel = 1'b0;
    tick(8 - hold);
  endtask

  task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    n_vec++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    wif.i_coin_raw   = 1'b0;
    wif.i_btn_mode   = 4'd0;
    wif.i_btn_cancel = 1'b0;
    wif.i_idle       = 1'b0;
    wif.i_ready      = 1'b0;
    wif.i_done       = 1'b0;
    tick(3);
    check_output("rst_start",  16'(wif.o_start),  16'd0);
    check_output("rst_credit", 16'(wif.o_credit), 16'd0);
    check_output("rst_coin",   16'(wif.o_coin),   16'd0);
    check_output("rst_mode",   16'(modes()),      16'd0);

    rst_n = 1'b1;
    tick(1);
    check_output("start_cycle1", 16'(wif.o_start),  16'd1);
    check_output("credit_init",  16'(wif.o_credit), 16'd0);
    tick(1);
    check_output("start_cycle2", 16'(wif.o_start),  16'd0);

    $display("[TB] debounce and first wash");
    apply_stimulus(COIN, 4);
    check_output("glitch_4cyc", 16'(wif.o_credit), 16'd0);
    apply_stimulus(COIN, 5);
    check_output("coin_5cyc", 16'(wif.o_credit), 16'd1);
    apply_stimulus(COIN, 5);
    apply_stimulus(COIN, 5);
    check_output("three_coins",     16'(wif.o_credit), 16'd3);
    check_output("no_coin_wo_idle", 16'(wif.o_coin),   16'd0);
    wif.i_idle = 1'b1; tick(1); wif.i_idle = 1'b0;
    check_output("coin_level",  16'(wif.o_coin),   16'd1);
    check_output("price_taken", 16'(wif.o_credit), 16'd0);
    tick(2);
    check_output("coin_held", 16'(wif.o_coin), 16'd1);
    wif.i_ready = 1'b1; tick(1); wif.i_ready = 1'b0;
    check_output("coin_drop", 16'(wif.o_coin), 16'd0);
    apply_stimulus(mode_bits(1), 5);
    check_output("mode2_latched", 16'(modes()), 16'b0010);
    tick(3);
    check_output("mode2_held", 16'(modes()), 16'b0010);
    wif.i_done = 1'b1; tick(1); wif.i_done = 1'b0;
    check_output("mode_clear_done",   16'(modes()),      16'd0);
    check_output("credit_after_wash", 16'(wif.o_credit), 16'd0);

    $display("[TB] simultaneous modes 1 and 3");
    repeat (3) apply_stimulus(COIN, 5);
    wif.i_idle = 1'b1; tick(1); wif.i_idle = 1'b0;
    wif.i_ready = 1'b1; tick(1); wif.i_ready = 1'b0;
    apply_stimulus(mode_bits(0) | mode_bits(2), 5);
    check_output("lowest_mode_wins", 16'(modes()), 16'b0001);
    wif.i_done = 1'b1; tick(1); wif.i_done = 1'b0;

    $display("[TB] select timeout");
    repeat (3) apply_stimulus(COIN, 5);
    wif.i_idle = 1'b1; tick(1); wif.i_idle = 1'b0;
    check_output("coin_level_2", 16'(wif.o_coin), 16'd1);
    wif.i_ready = 1'b1; tick(1); wif.i_ready = 1'b0;
    tick(SEL_TIMEOUT - 1);
    check_output("no_cancel_early", 16'(wif.o_cancel), 16'd0);
    tick(1);
    check_output("timeout_cancel", 16'(wif.o_cancel), 16'd1);
    check_output("timeout_refund", 16'(wif.o_credit), 16'd3);
    tick(1);
    check_output("cancel_one_cycle", 16'(wif.o_cancel), 16'd0);

    $display("[TB] abort recovery and cancel in coin state");
    wif.i_idle = 1'b1; tick(1); wif.i_idle = 1'b0;
    wif.i_idle = 1'b1; tick(1); wif.i_idle = 1'b0;
    check_output("abort_to_credit_coin", 16'(wif.o_coin),   16'd1);
    check_output("abort_credit_taken",   16'(wif.o_credit), 16'd0);
    apply_stimulus(CANCEL, 5);
    check_output("cancel_in_coin",    16'(wif.o_cancel), 16'd1);
    check_output("coin_drop_cancel",  16'(wif.o_coin),   16'd0);
    check_output("coin_cancel_refund", 16'(wif.o_credit), 16'd3);
    apply_stimulus(CANCEL, 5);
    check_output("cancel_in_abort",    16'(wif.o_cancel), 16'd0);
    check_output("no_refund_in_abort", 16'(wif.o_refund), 16'd0);
    wif.i_idle = 1'b1; tick(1); wif.i_idle = 1'b0;
    apply_stimulus(CANCEL, 5);
    check_output("refund3_strobe", 16'(wif.o_refund),     16'd1);
    check_output("refund3_cnt",    16'(wif.o_refund_cnt), 16'd3);
    check_output("refund3_clear",  16'(wif.o_credit),     16'd0);
    tick(1);
    check_output("refund_one_cycle", 16'(wif.o_refund), 16'd0);

    $display("[TB] refund of two credits and saturation");
    repeat (2) apply_stimulus(COIN, 5);
    check_output("two_coins", 16'(wif.o_credit), 16'd2);
    apply_stimulus(CANCEL, 5);
    check_output("refund2_strobe", 16'(wif.o_refund),     16'd1);
    check_output("refund2_cnt",    16'(wif.o_refund_cnt), 16'd2);
    tick(1);
    check_output("refund2_credit", 16'(wif.o_credit), 16'd0);
    repeat (16) apply_stimulus(COIN, 5);
    check_output("credit_saturate", 16'(wif.o_credit), 16'd15);

    $display("[TB] cancel during run");
    wif.i_idle = 1'b1; tick(1); wif.i_idle = 1'b0;
    check_output("credit_15_minus_price", 16'(wif.o_credit), 16'd12);
    wif.i_ready = 1'b1; tick(1); wif.i_ready = 1'b0;
    apply_stimulus(mode_bits(3), 5);
    check_output("mode4_latched", 16'(modes()), 16'b1000);
    apply_stimulus(mode_bits(0), 5);
    check_output("mode_ignored_in_run", 16'(modes()), 16'b1000);
    apply_stimulus(CANCEL, 5);
    check_output("cancel_in_run",    16'(wif.o_cancel), 16'd1);
    check_output("run_cancel_mode",  16'(modes()),      16'd0);
    check_output("run_cancel_credit", 16'(wif.o_credit), 16'd12);

    $display("[TB] cancel and mode together in select");
    wif.i_idle = 1'b1; tick(2); wif.i_idle = 1'b0;
    check_output("coin_level_3", 16'(wif.o_coin),   16'd1);
    check_output("credit_9",     16'(wif.o_credit), 16'd9);
    wif.i_ready = 1'b1; tick(1); wif.i_ready = 1'b0;
    apply_stimulus(CANCEL | mode_bits(2), 5);
    check_output("cancel_beats_mode",   16'(wif.o_cancel), 16'd1);
    check_output("no_mode_on_cancel",   16'(modes()),      16'd0);
    check_output("select_cancel_refund", 16'(wif.o_credit), 16'd12);

    $display("[TB] asynchronous reset mid-run");
    wif.i_idle = 1'b1; tick(2); wif.i_idle = 1'b0;
    wif.i_ready = 1'b1; tick(1); wif.i_ready = 1'b0;
    apply_stimulus(mode_bits(2), 5);
    check_output("mode3_latched", 16'(modes()),      16'b0100);
    check_output("credit_9_run",  16'(wif.o_credit), 16'd9);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_rst_mode",   16'(modes()),      16'd0);
    check_output("async_rst_credit", 16'(wif.o_credit), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    check_output("restart_pulse", 16'(wif.o_start), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
